// File: rtl/gmii_rx_frame_checker_if.sv
// Signal bundle between the GMII receive pins, the frame checker and the
// downstream parser. The checker takes the slave view; the PHY/parser side
// (or a bench) takes the master view.
interface gmii_rx_frame_checker_if;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_err;

    logic        o_sof;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_eof;
    logic        o_ok;
    logic [2:0]  o_err_code;
    logic [15:0] o_len;
    logic [31:0] o_cnt_ok;
    logic [31:0] o_cnt_bad;

    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_err,
        input  o_sof, o_data, o_valid, o_eof, o_ok, o_err_code, o_len,
               o_cnt_ok, o_cnt_bad
    );

    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_err,
        output o_sof, o_data, o_valid, o_eof, o_ok, o_err_code, o_len,
               o_cnt_ok, o_cnt_bad
    );
endinterface

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive front-end: locks on preamble/SFD, streams frame bytes,
// checks CRC-32 and length limits, optionally strips the FCS, enforces a
// minimum inter-frame gap and keeps good/bad frame counters.
//
// state | meaning
// IDLE  | line quiet, waiting for the first 0x55 octet
// PRE   | counting preamble octets, waiting for SFD
// DATA  | inside a frame, bytes counted, CRC'd and forwarded
// DROP  | discarding the rest of a burst until dv falls
// IFG   | counting dv-low cycles before a new preamble is allowed
module gmii_rx_frame_checker #(
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int STRIP_FCS = 1,
    parameter int PRE_MIN   = 1,
    parameter int IFG_MIN   = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    gmii_rx_frame_checker_if.slave bus
);

    localparam logic [15:0] MIN_LEN_C   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_C   = 16'(MAX_LEN);
    localparam logic [15:0] GIANT_LEN_C = 16'(MAX_LEN + 1);
    localparam logic [15:0] IFG_MIN_C   = 16'(IFG_MIN);
    localparam logic [7:0]  PRE_MIN_C   = 8'(PRE_MIN);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_PHY   = 3'd1;
    localparam logic [2:0] ERR_CRC   = 3'd2;
    localparam logic [2:0] ERR_RUNT  = 3'd3;
    localparam logic [2:0] ERR_GIANT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_DROP = 3'd3,
        S_IFG  = 3'd4
    } state_t;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    logic [7:0]  rxd_q;
    logic        dv_q;
    logic        err_q;

    state_t      state_q, state_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [15:0] ifg_q, ifg_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] len_q, len_d;

    logic        push;
    logic        frame_start;
    logic        frame_end;
    logic [2:0]  end_code;
    logic [15:0] end_len;

    logic [31:0] line_q;
    logic [2:0]  fill_q;
    logic        sof_pend_q;

    logic        sof_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        eof_q;
    logic        ok_q;
    logic [2:0]  code_q;
    logic [15:0] olen_q;
    logic [31:0] cnt_ok_q;
    logic [31:0] cnt_bad_q;

    // Register the raw GMII pins once; everything downstream uses these copies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_q <= 8'd0;
            dv_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            rxd_q <= bus.gmii_rxd;
            dv_q  <= bus.gmii_rx_dv;
            err_q <= bus.gmii_rx_err;
        end
    end

    // FSM state and per-frame bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pcnt_q  <= 8'd0;
            ifg_q   <= 16'd0;
            crc_q   <= 32'd0;
            len_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            ifg_q   <= ifg_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
        end
    end

    // Next-state, frame-end detection and error classification.
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        ifg_d       = ifg_q;
        crc_d       = crc_q;
        len_d       = len_q;
        push        = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        end_code    = ERR_OK;
        end_len     = len_q;

        case (state_q)
            S_IDLE: begin
                if (dv_q) begin
                    if (rxd_q == 8'h55) begin
                        state_d = S_PRE;
                        pcnt_d  = 8'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end

            S_PRE: begin
                if (!dv_q) begin
                    state_d = S_IDLE;
                end else if (err_q) begin
                    state_d = S_DROP;
                end else if (rxd_q == 8'h55) begin
                    if (pcnt_q != 8'hFF) begin
                        pcnt_d = pcnt_q + 8'd1;
                    end
                end else if ((rxd_q == 8'hD5) && (pcnt_q >= PRE_MIN_C)) begin
                    state_d     = S_DATA;
                    crc_d       = CRC_INIT;
                    len_d       = 16'd0;
                    frame_start = 1'b1;
                end else begin
                    state_d = S_DROP;
                end
            end

            S_DATA: begin
                if (!dv_q) begin
                    frame_end = 1'b1;
                    state_d   = S_IFG;
                    ifg_d     = 16'd1;
                    if (len_q < MIN_LEN_C) begin
                        end_code = ERR_RUNT;
                    end else if (crc_q != CRC_RESIDUE) begin
                        end_code = ERR_CRC;
                    end else begin
                        end_code = ERR_OK;
                    end
                end else if (err_q) begin
                    frame_end = 1'b1;
                    end_code  = ERR_PHY;
                    state_d   = S_DROP;
                end else if (len_q == MAX_LEN_C) begin
                    // This byte would be number MAX_LEN+1: count it, never forward it.
                    frame_end = 1'b1;
                    end_code  = ERR_GIANT;
                    end_len   = GIANT_LEN_C;
                    len_d     = GIANT_LEN_C;
                    state_d   = S_DROP;
                end else begin
                    push  = 1'b1;
                    crc_d = crc_step(crc_q, rxd_q);
                    len_d = len_q + 16'd1;
                end
            end

            S_DROP: begin
                if (!dv_q) begin
                    state_d = S_IFG;
                    ifg_d   = 16'd1;
                end
            end

            S_IFG: begin
                if (dv_q) begin
                    state_d = S_DROP;
                end else if ((ifg_q + 16'd1) >= IFG_MIN_C) begin
                    state_d = S_IDLE;
                end else begin
                    ifg_d = ifg_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output byte pipe; with FCS stripping a byte leaves only when a newer one pushes it out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q     <= 32'd0;
            fill_q     <= 3'd0;
            sof_pend_q <= 1'b0;
            sof_q      <= 1'b0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
        end else begin
            sof_q   <= 1'b0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            if (frame_start) begin
                fill_q     <= 3'd0;
                sof_pend_q <= 1'b1;
            end else if (frame_end) begin
                fill_q     <= 3'd0;
                sof_pend_q <= 1'b0;
            end else if (push) begin
                if (STRIP_FCS != 0) begin
                    line_q <= {line_q[23:0], rxd_q};
                    if (fill_q == 3'd4) begin
                        valid_q    <= 1'b1;
                        data_q     <= line_q[31:24];
                        sof_q      <= sof_pend_q;
                        sof_pend_q <= 1'b0;
                    end else begin
                        fill_q <= fill_q + 3'd1;
                    end
                end else begin
                    valid_q    <= 1'b1;
                    data_q     <= rxd_q;
                    sof_q      <= sof_pend_q;
                    sof_pend_q <= 1'b0;
                end
            end
        end
    end

    // End-of-frame status and good/bad counters, updated on the cycle o_eof is shown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eof_q     <= 1'b0;
            ok_q      <= 1'b0;
            code_q    <= ERR_OK;
            olen_q    <= 16'd0;
            cnt_ok_q  <= 32'd0;
            cnt_bad_q <= 32'd0;
        end else begin
            eof_q  <= frame_end;
            ok_q   <= frame_end && (end_code == ERR_OK);
            code_q <= frame_end ? end_code : ERR_OK;
            olen_q <= frame_end ? end_len : 16'd0;
            if (frame_end) begin
                if (end_code == ERR_OK) begin
                    cnt_ok_q <= cnt_ok_q + 32'd1;
                end else begin
                    cnt_bad_q <= cnt_bad_q + 32'd1;
                end
            end
        end
    end

    assign bus.o_sof      = sof_q;
    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_eof      = eof_q;
    assign bus.o_ok       = ok_q;
    assign bus.o_err_code = code_q;
    assign bus.o_len      = olen_q;
    assign bus.o_cnt_ok   = cnt_ok_q;
    assign bus.o_cnt_bad  = cnt_bad_q;

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Bench for gmii_rx_frame_checker: directed and random frames, expected
// bytes and end-of-frame records queued by the driver, checked by a
// negedge monitor.
module tb_gmii_rx_frame_checker;

    localparam int MIN_LEN   = 64;
    localparam int MAX_LEN   = 1518;
    localparam int STRIP_FCS = 1;
    localparam int PRE_MIN   = 1;
    localparam int IFG_MIN   = 12;
    localparam int LAT       = (STRIP_FCS != 0) ? 6 : 2;
    localparam int HOLD      = (STRIP_FCS != 0) ? 4 : 0;

    typedef struct {
        logic [7:0] d;
        bit         sof;
        int         cyc;
    } exp_byte_t;

    typedef struct {
        bit          ok;
        logic [2:0]  code;
        int          len;
        int unsigned cnt_ok;
        int unsigned cnt_bad;
        int          cyc;
    } exp_eof_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   done  = 1'b0;

    exp_byte_t   exp_bytes[$];
    exp_eof_t    exp_eofs[$];
    logic [7:0]  body [0:1699];
    int          last_gap = 0;
    int unsigned m_cnt_ok = 0;
    int unsigned m_cnt_bad = 0;

    gmii_rx_frame_checker_if bus_if();

    gmii_rx_frame_checker #(
        .MIN_LEN  (MIN_LEN),
        .MAX_LEN  (MAX_LEN),
        .STRIP_FCS(STRIP_FCS),
        .PRE_MIN  (PRE_MIN),
        .IFG_MIN  (IFG_MIN)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus_if)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required done", cyc);
        $fatal(1, "watchdog");
    end

    // Ethernet FCS of body[0..n-1], bit-serial textbook form.
    function automatic logic [31:0] ref_fcs(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ body[i][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
                else                             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic drive(input logic dv, input logic err, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus_if.gmii_rx_dv  = dv;
        bus_if.gmii_rx_err = err;
        bus_if.gmii_rxd    = d;
    endtask

    task automatic send_frame(input int npre, input int nbody, input bit corrupt,
                              input int err_at, input int reset_at, input int gap);
        logic [31:0] fcs;
        logic [7:0]  d;
        logic [2:0]  code;
        bit          good, accept, has_err;
        int          k, pushed, emit, endidx, len, t0;
        exp_byte_t   eb;
        exp_eof_t    ee;

        for (int i = 0; i < nbody; i++) body[i] = 8'($urandom);
        good = 1'b0;
        if (nbody >= 4) begin
            fcs = ref_fcs(nbody - 4);
            for (int j = 0; j < 4; j++) body[nbody - 4 + j] = fcs[8*j +: 8];
            if (corrupt && nbody > 4) body[0] = body[0] ^ 8'h08;
            good = ({body[nbody-1], body[nbody-2], body[nbody-3], body[nbody-4]} == ref_fcs(nbody - 4));
        end

        accept  = (npre >= PRE_MIN) && (last_gap >= IFG_MIN);
        has_err = (err_at >= 0) && (err_at < nbody);
        k       = has_err ? err_at : nbody;
        if (k > MAX_LEN) begin
            code = 3'd4; len = MAX_LEN + 1; pushed = MAX_LEN; endidx = MAX_LEN;
        end else begin
            pushed = k; endidx = k; len = k;
            if (has_err)          code = 3'd1;
            else if (k < MIN_LEN) code = 3'd3;
            else if (!good)       code = 3'd2;
            else                  code = 3'd0;
        end
        emit = pushed - HOLD;
        if (emit < 0) emit = 0;
        if (reset_at >= 0 && emit > reset_at - LAT) emit = (reset_at - LAT > 0) ? reset_at - LAT : 0;

        for (int j = 0; j < npre + 1 + nbody; j++) begin
            if (reset_at >= 0 && j == npre + 1 + reset_at) begin
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                bus_if.gmii_rx_dv  = 1'b0;
                bus_if.gmii_rx_err = 1'b0;
                bus_if.gmii_rxd    = 8'd0;
                repeat (3) @(posedge clk);
                #1;
                rst_n     = 1'b1;
                m_cnt_ok  = 0;
                m_cnt_bad = 0;
                break;
            end
            if (j < npre)       d = 8'h55;
            else if (j == npre) d = 8'hD5;
            else                d = body[j - npre - 1];
            drive(1'b1, has_err && (j == npre + 1 + err_at), d);
            if (j == 0) begin
                t0 = cyc + npre + 1;
                if (accept) begin
                    for (int i = 0; i < emit; i++) begin
                        eb.d = body[i]; eb.sof = (i == 0); eb.cyc = t0 + i + LAT;
                        exp_bytes.push_back(eb);
                    end
                    if (reset_at < 0) begin
                        if (code == 3'd0) m_cnt_ok++;
                        else              m_cnt_bad++;
                        ee.ok = (code == 3'd0); ee.code = code; ee.len = len;
                        ee.cnt_ok = m_cnt_ok; ee.cnt_bad = m_cnt_bad;
                        ee.cyc = t0 + endidx + 2;
                        exp_eofs.push_back(ee);
                    end
                end
            end
        end
        repeat (gap) drive(1'b0, 1'b0, 8'd0);
        last_gap = (reset_at >= 0) ? IFG_MIN + gap : gap;
    endtask

    // Stimulus
    initial begin
        int npre, nbody, err_at, gap;
        bit corrupt;
        bus_if.gmii_rxd    = 8'd0;
        bus_if.gmii_rx_dv  = 1'b0;
        bus_if.gmii_rx_err = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) drive(1'b0, 1'b0, 8'd0);
        last_gap = 20;

        send_frame(7, 64,   1'b0, -1, -1, 12);   // good minimum frame
        send_frame(7, 64,   1'b1, -1, -1, 12);   // CRC error
        send_frame(7, 40,   1'b0, -1, -1, 12);   // runt with good FCS
        send_frame(7, 3,    1'b0, -1, -1, 12);   // tiny runt, nothing emitted
        send_frame(7, 1600, 1'b0, -1, -1, 12);   // giant
        send_frame(7, 64,   1'b0, -1, -1, 12);
        send_frame(7, 100,  1'b0, 20, -1, 12);   // PHY error at byte 20
        send_frame(7, 64,   1'b0, -1, -1, 5);
        send_frame(7, 64,   1'b0, -1, -1, 11);   // dropped: gap 5 before
        send_frame(7, 64,   1'b0, -1, -1, 12);   // dropped: gap 11 before
        send_frame(7, 1518, 1'b0, -1, -1, 12);   // largest legal frame
        send_frame(7, 80,   1'b0, -1, 30, 12);   // reset mid-frame
        send_frame(7, 64,   1'b0, -1, -1, 12);

        for (int r = 0; r < 25; r++) begin
            npre    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
            nbody   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 63)) : int'($urandom_range(60, 200));
            corrupt = ($urandom_range(0, 3) == 0);
            err_at  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nbody - 1)) : -1;
            gap     = int'($urandom_range(9, 15));
            send_frame(npre, nbody, corrupt, err_at, -1, gap);
        end
        send_frame(7, 64, 1'b0, -1, -1, 12);
        repeat (20) drive(1'b0, 1'b0, 8'd0);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        exp_byte_t mb;
        exp_eof_t  me;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tests++;
                if (bus_if.o_valid || bus_if.o_sof || bus_if.o_eof || bus_if.o_ok ||
                    bus_if.o_data != 8'd0 || bus_if.o_err_code != 3'd0 || bus_if.o_len != 16'd0 ||
                    bus_if.o_cnt_ok != 32'd0 || bus_if.o_cnt_bad != 32'd0) begin
                    fails++;
                    $display("FAIL reset_outputs cyc=%0d valid=%0d eof=%0d data=%h len=%0d ok_cnt=%0d bad_cnt=%0d required all 0",
                             cyc, bus_if.o_valid, bus_if.o_eof, bus_if.o_data, bus_if.o_len,
                             bus_if.o_cnt_ok, bus_if.o_cnt_bad);
                end
            end else begin
                tests++;
                if (bus_if.o_valid) begin
                    if (exp_bytes.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_byte cyc=%0d got=%h required no byte", cyc, bus_if.o_data);
                    end else begin
                        mb = exp_bytes.pop_front();
                        if (bus_if.o_data != mb.d || bus_if.o_sof != mb.sof || cyc != mb.cyc) begin
                            fails++;
                            $display("FAIL byte got data=%h sof=%0d cyc=%0d required data=%h sof=%0d cyc=%0d",
                                     bus_if.o_data, bus_if.o_sof, cyc, mb.d, mb.sof, mb.cyc);
                        end
                    end
                end else if (bus_if.o_sof || bus_if.o_data != 8'd0) begin
                    fails++;
                    $display("FAIL idle_data cyc=%0d sof=%0d data=%h required 0/00", cyc, bus_if.o_sof, bus_if.o_data);
                end

                if (bus_if.o_eof) begin
                    tests++;
                    if (bus_if.o_valid) begin
                        fails++;
                        $display("FAIL eof_with_valid cyc=%0d valid=1 required 0", cyc);
                    end
                    if (exp_eofs.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_eof cyc=%0d code=%0d len=%0d required no eof",
                                 cyc, bus_if.o_err_code, bus_if.o_len);
                    end else begin
                        me = exp_eofs.pop_front();
                        tests++;
                        if (bus_if.o_err_code != me.code || bus_if.o_ok != me.ok) begin
                            fails++;
                            $display("FAIL eof_code got code=%0d ok=%0d required code=%0d ok=%0d",
                                     bus_if.o_err_code, bus_if.o_ok, me.code, me.ok);
                        end
                        tests++;
                        if (bus_if.o_len != 16'(me.len)) begin
                            fails++;
                            $display("FAIL eof_len got=%0d required=%0d", bus_if.o_len, me.len);
                        end
                        tests++;
                        if (bus_if.o_cnt_ok != 32'(me.cnt_ok) || bus_if.o_cnt_bad != 32'(me.cnt_bad)) begin
                            fails++;
                            $display("FAIL counters got ok=%0d bad=%0d required ok=%0d bad=%0d",
                                     bus_if.o_cnt_ok, bus_if.o_cnt_bad, me.cnt_ok, me.cnt_bad);
                        end
                        tests++;
                        if (cyc != me.cyc) begin
                            fails++;
                            $display("FAIL eof_timing got cyc=%0d required cyc=%0d", cyc, me.cyc);
                        end
                    end
                end else begin
                    tests++;
                    if (bus_if.o_ok || bus_if.o_err_code != 3'd0 || bus_if.o_len != 16'd0) begin
                        fails++;
                        $display("FAIL status_without_eof cyc=%0d ok=%0d code=%0d len=%0d required 0",
                                 cyc, bus_if.o_ok, bus_if.o_err_code, bus_if.o_len);
                    end
                end

                if (done) begin
                    tests++;
                    if (exp_bytes.size() != 0 || exp_eofs.size() != 0) begin
                        fails++;
                        $display("FAIL leftover_expectations bytes=%0d eofs=%0d required 0/0",
                                 exp_bytes.size(), exp_eofs.size());
                    end
                    $display("[TB] %0d tests run, %0d failed", tests, fails);
                    $finish;
                end
            end
        end
    end

endmodule
